// File: rtl/output_streamer.sv
// output_streamer: walks a slot range of the output register file and streams each 16-bit word as two bytes, high first.
// Optional OUTPUT_STREAMER_CHECKSUM_EN appends an XOR checksum byte after the last word.
module output_streamer #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_index,
    input  logic [ADDR_W-1:0] last_index,
    output logic [ADDR_W-1:0] rd_index,
    input  logic [15:0]       rd_value,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND_HI, SEND_LO, CHK, DONE} state_t;
    logic [7:0] chk;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEND_HI, SEND_LO, DONE} state_t;
`endif
    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last;
    logic [15:0]       word;

    assign rd_index = cur;

    // tx_data/tx_valid are loaded one state ahead so they never depend on tx_ready combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            last     <= '0;
            word     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
            chk      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur   <= first_index;
                    last  <= last_index;
                    busy  <= 1'b1;
                    state <= FETCH;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
                    chk   <= '0;
`endif
                end
                FETCH: begin
                    word     <= rd_value;
                    tx_data  <= rd_value[15:8];
                    tx_valid <= 1'b1;
                    state    <= SEND_HI;
                end
                SEND_HI: if (tx_ready) begin
                    tx_data <= word[7:0];
                    state   <= SEND_LO;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
                    chk     <= chk ^ word[15:8];
`endif
                end
                SEND_LO: if (tx_ready) begin
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
                    chk <= chk ^ word[7:0];
`endif
                    if (cur == last) begin
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
                        tx_data <= chk ^ word[7:0];
                        state   <= CHK;
`else
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
`endif
                    end else begin
                        cur      <= cur + 1'b1;
                        tx_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
                CHK: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_streamer.sv
// tb_output_streamer: directed stimulus with a queue-based stream model checked every cycle.
module tb_output_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_index = '0;
    logic [4:0]  last_index = '0;
    logic [4:0]  rd_index;
    logic [15:0] rd_value;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [15:0] mem [32];
    logic [7:0]  exp_q [$];
    int          exp_idx [$];
    int          log_byte [$];
    int          log_cyc [$];
    int          log_idx [$];
    int          cyc = 0;
    int          t0 = 0;
    int          byte_n = 0;
    int          done_cyc = -1;
    bit          done_seen = 1'b0;
    bit          prev_v = 1'b0;
    bit          prev_acc = 1'b0;
    logic [7:0]  prev_d = '0;
    int          n_checks = 0;
    int          n_err = 0;

    output_streamer #(.ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .first_index(first_index),
        .last_index(last_index), .rd_index(rd_index), .rd_value(rd_value),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    assign rd_value = mem[rd_index];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream is derived from the slot contents at start time.
    task automatic start_dump(input int f, input int l);
        int n;
        logic [7:0] x;
        exp_q.delete(); exp_idx.delete();
        log_byte.delete(); log_cyc.delete(); log_idx.delete();
        byte_n = 0; done_seen = 0; done_cyc = -1; x = '0;
        n = ((l - f) & 31) + 1;
        for (int i = 0; i < n; i++) begin
            int s;
            s = (f + i) % 32;
            exp_idx.push_back(s);
            exp_q.push_back(mem[s][15:8]);
            exp_q.push_back(mem[s][7:0]);
            x = x ^ mem[s][15:8] ^ mem[s][7:0];
        end
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        first_index = 5'(f);
        last_index = 5'(l);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick();
        if (!done_seen) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout: done not seen within %0d cycles", budget);
        end
        tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_idx.delete();
            prev_v = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (prev_v && !prev_acc) begin
                chk("hold_valid", int'(tx_valid), 1);
                chk("hold_data", int'(tx_data), int'(prev_d));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL extra_byte: got 0x%0h, expected no byte", tx_data);
                end else chk("byte", int'(tx_data), int'(exp_q.pop_front()));
                if (byte_n % 2 == 0 && exp_idx.size() > 0) begin
                    log_idx.push_back(int'(rd_index));
                    chk("rd_index", int'(rd_index), exp_idx.pop_front());
                end
                log_byte.push_back(int'(tx_data));
                log_cyc.push_back(cyc - t0);
                byte_n++;
            end
            if (done) begin
                chk("done_drained", exp_q.size(), 0);
                done_seen = 1'b1;
                done_cyc = cyc - t0;
            end
            prev_v = tx_valid;
            prev_acc = tx_valid && tx_ready;
            prev_d = tx_data;
        end
    end

    initial begin
        int ext;
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
        ext = 1;
`else
        ext = 0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 16'(i * 16'h0101 + 16'h1000);
        tick(); tick();
        rst = 1'b0;
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_index", int'(rd_index), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        tick();

        // single slot
        mem[4] = 16'hBEEF;
        start_dump(4, 4);
        chk("single_busy", int'(busy), 1);
        wait_done(40);
        chk("single_b0", log_byte[0], 'hBE);
        chk("single_c0", log_cyc[0], 2);
        chk("single_b1", log_byte[1], 'hEF);
        chk("single_c1", log_cyc[1], 3);
`ifdef OUTPUT_STREAMER_CHECKSUM_EN
        chk("single_chk", log_byte[2], 'h51);
        chk("single_chk_c", log_cyc[2], 4);
`endif
        chk("single_done_c", done_cyc, 4 + ext);
        chk("single_idle_busy", int'(busy), 0);

        // wrap-around range 30,31,0
        mem[30] = 16'h1234; mem[31] = 16'h5678; mem[0] = 16'h9ABC;
        start_dump(30, 0);
        wait_done(60);
        chk("wrap_count", log_byte.size(), 6 + ext);
        chk("wrap_b0", log_byte[0], 'h12);
        chk("wrap_b3", log_byte[3], 'h78);
        chk("wrap_b5", log_byte[5], 'hBC);
        chk("wrap_i0", log_idx[0], 30);
        chk("wrap_i1", log_idx[1], 31);
        chk("wrap_i2", log_idx[2], 0);
        chk("wrap_done_c", done_cyc, 10 + ext);

        // backpressure: ready low for 5 SEND_HI cycles
        mem[7] = 16'hA55A;
        tx_ready = 1'b0;
        start_dump(7, 7);
        repeat (6) tick();
        chk("bp_valid_held", int'(tx_valid), 1);
        chk("bp_data_held", int'(tx_data), 'hA5);
        tx_ready = 1'b1;
        wait_done(40);
        chk("bp_hi_c", log_cyc[0], 7);
        chk("bp_lo_c", log_cyc[1], 8);
        chk("bp_lo_b", log_byte[1], 'h5A);

        // write race on slot 3 in its FETCH cycle plus a start while busy
        mem[3] = 16'h00FF; mem[4] = 16'h1111; mem[20] = 16'hDEAD;
        start_dump(3, 4);
        @(posedge clk);
        mem[3] <= 16'h0001;
        #1;
        tick();
        first_index = 5'd20; last_index = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(60);
        chk("race_count", log_byte.size(), 4 + ext);
        chk("race_b0", log_byte[0], 'h00);
        chk("race_b1", log_byte[1], 'hFF);
        chk("race_b2", log_byte[2], 'h11);
        chk("race_mem_written", int'(mem[3]), 'h0001);
        tick();
        chk("race_no_restart", int'(busy), 0);

        // reset in the middle of a 32-slot dump
        start_dump(0, 31);
        repeat (31) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", int'(tx_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_bytes", log_byte.size() >= 18 ? 1 : 0, 1);
        repeat (10) tick();
        chk("mid_rst_no_done", int'(done_seen), 0);
        start_dump(5, 8);
        wait_done(80);
        chk("restart_count", log_byte.size(), 8 + ext);
        chk("restart_i0", log_idx[0], 5);
        chk("restart_done_c", done_cyc, 13 + ext);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/output_streamer.md
# output_streamer

Drain-side companion to the accumulator output register file. On a start pulse it walks a range of output-register slots, reads each 16-bit result through the register file's combinational read port, and emits it as two bytes (high byte first) on a valid/ready byte stream toward external logic (UART TX, debug port). It is the only reader of stored results; the accumulator remains the only writer.

## Interface
- `ADDR_W`, default 5: slot index width; 2^ADDR_W slots (32).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a dump; sampled only in IDLE.
- `first_index` in ADDR_W: first slot to send; latched on accepted start.
- `last_index` in ADDR_W: last slot to send; latched on accepted start.
- `rd_index` out ADDR_W: slot index driven to the output register read port.
- `rd_value` in 16: combinational read data for `rd_index`.
- `tx_data` out 8: stream byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts byte when high together with `tx_valid`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, FETCH, SEND_HI, SEND_LO, [CHK], DONE.
- IDLE: `start`=1 latches `first_index` into `cur` and `last_index` into `last`, clears checksum, goes to FETCH. Otherwise stays.
- FETCH: `rd_index`=`cur`; captures `rd_value` into `word` at the clock edge; goes to SEND_HI.
- SEND_HI: `tx_valid`=1, `tx_data`=`word[15:8]`; stays until `tx_ready`=1, then SEND_LO.
- SEND_LO: `tx_valid`=1, `tx_data`=`word[7:0]`; on `tx_ready`: if `cur`==`last`, goes to CHK (macro on) or DONE; otherwise `cur`<=`cur`+1 mod 2^ADDR_W and goes to FETCH.
- DONE: `done`=1 for this cycle only; next state IDLE.
- Range wrap-around: if `last_index` < `first_index`, the index wraps from 31 to 0; `first_index`==`last_index` sends exactly one slot. Word count = ((last−first) mod 32)+1, range 1..32.
- `start` outside IDLE is ignored; no queuing.
- Concurrent accumulator write to the slot being fetched in the same cycle: the pre-write value is captured (register file updates at the edge). Later writes do not affect `word`.
- `rd_index` is the `cur` register; it holds its last value in IDLE/DONE.

## Timing
- Reset values: state IDLE, `cur`=0, `last`=0, `word`=0, `rd_index`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, checksum=0.
- `rst` wins over all other inputs; reset mid-dump aborts without a `done` pulse; `tx_valid` low after that edge.
- Start in cycle 0 → FETCH in cycle 1 → `tx_valid` first high in cycle 2.
- Stream rule: once `tx_valid` is high, `tx_data` is stable and `tx_valid` stays high until the handshake; no bubbles between HI and LO of a word.
- With `tx_ready` held high: 3 cycles per word; N words → last data byte accepted in cycle 3N, `done` in cycle 3N+1 (macro off).
- All outputs registered or decoded from state/registers only; no combinational path from `tx_ready` to `tx_valid`/`tx_data`.

## Configuration
- `OUTPUT_STREAMER_CHECKSUM_EN` defined: every accepted byte is XORed into an 8-bit checksum; after the last SEND_LO, state CHK presents `tx_data`=checksum with `tx_valid`=1 under the same handshake, then DONE. Adds one byte and one cycle (ready-high case: `done` in cycle 3N+2).
- Undefined: no CHK state, no checksum register; SEND_LO of the last word goes directly to DONE.

## Test plan
- Single slot: slot 4=0xBEEF, first=last=4, `tx_ready`=1 → bytes 0xBE, 0xEF in cycles 2,3; `done` in cycle 4 (macro off) or checksum 0x51 then `done` cycle 5 (macro on).
- Wrap range: slots 30,31,0 = 0x1234,0x5678,0x9ABC, first=30, last=0 → bytes 12 34 56 78 9A BC in order, `rd_index` sequence 30,31,0.
- Backpressure: `tx_ready` low for 5 cycles during SEND_HI of 0xA55A → `tx_valid`=1 and `tx_data`=0xA5 held all 5 cycles; 0x5A follows immediately after accept.
- Ignored start and write race: second `start` while busy → no restart; accumulator writes 0x0001 to slot 3 in its FETCH cycle over old 0x00FF → 0x00FF sent.
- Reset mid-dump: 32-slot dump, `rst` pulsed during word 10 → next cycle `tx_valid`=0, `busy`=0, no `done`; new start sends from its `first_index` correctly.
